// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file: data types, the default
// register file depth, the port-count limits and the register reset image.
package cpu_pkg;

   typedef logic [31:0]        reg_t;
   typedef logic signed [31:0] sint32_t;

   localparam int RF_DEPTH_DEFAULT = 16;
   localparam int RF_MAX_RD        = 4;
   localparam int RF_MAX_WR        = 2;

   // Reset image for the first 16 registers; anything not listed starts at zero.
   localparam reg_t RF_INIT [16] = '{
      32'h0000_0000, 32'h0000_0040, 32'h0000_0060, 32'h0000_0000,
      32'h0000_0002, 32'h0000_0040, 32'h0000_0000, 32'hFFFF_856D,
      32'hEEEE_3721, 32'h0000_0000, 32'h1FFF_756F, 32'hFFFF_765E,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
   };

   // Reset value for register idx, so deeper register files still get a
   // defined image (zero beyond the table).
   function automatic reg_t rf_init_val(input int idx);
      if (idx >= 0 && idx < 16) begin
         return RF_INIT[idx];
      end
      return '0;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the register file: one bit per register, set when a
// producer is issued (reservation) and cleared when its result is written back.
module rf_scoreboard
   import cpu_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH_DEFAULT,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [DEPTH-1:0]         busy_vec
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Writes clear first, then a reservation sets, so a newer producer issued in
   // the same cycle as the old one's writeback keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w]) begin
            busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (rsv_en) begin
         busy_d[rsv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Busy flops; reset clears every in-flight reservation.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with registered read ports, multiple writeback
// ports and a busy scoreboard. Optional macro RF_BYPASS_EN forwards same-cycle
// write data and post-update busy into colliding reads; without it reads see
// the contents and busy state from before the edge.
module rf_multiport
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = RF_DEPTH_DEFAULT,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int ADDR_W  = $clog2(DEPTH)
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [DEPTH-1:0]         busy_vec
);

   logic [DATA_W-1:0] regs [DEPTH];

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   // Register storage; ports are visited in ascending order so the last
   // non-blocking assignment (highest port index) wins an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= DATA_W'(rf_init_val(i));
         end
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == '0)) begin
               regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_next;
      logic              busy_next;
      logic [DATA_W-1:0] data_q;
      logic              busy_q;

      assign addr = rd_addr[p*ADDR_W +: ADDR_W];

      // Value this port captures at the edge, including optional forwarding.
      always_comb begin
         data_next = regs[addr];
         busy_next = busy_vec[addr];
`ifdef RF_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
               data_next = wr_data[w*DATA_W +: DATA_W];
               busy_next = 1'b0;
            end
         end
         if (rsv_en && rsv_addr == addr) begin
            busy_next = 1'b1;
         end
`endif
         if (ZERO_REG != 0 && addr == '0) begin
            data_next = '0;
            busy_next = 1'b0;
         end
      end

      // Read port register; holds its last value while the port is idle.
      always_ff @(posedge clk) begin
         if (reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
         end else if (rd_en[p]) begin
            data_q <= data_next;
            busy_q <= busy_next;
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = data_q;
      assign rd_busy[p]                  = busy_q;
   end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport with two read and two write
// ports. Expectations follow RF_BYPASS_EN when the bench is built with it.
module tb_rf_multiport;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int ADDR_W = 4;

   logic                     clk;
   logic                     reset;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [DEPTH-1:0]         busy_vec;

   int checks = 0;
   int errors = 0;

   rf_multiport #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      rd_en  = '0;
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   task automatic set_read(input int p, input logic [ADDR_W-1:0] a);
      rd_en[p] = 1'b1;
      rd_addr[p*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic set_write(input int w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en[w] = 1'b1;
      wr_addr[w*ADDR_W +: ADDR_W] = a;
      wr_data[w*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_rsv(input logic [ADDR_W-1:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   // Apply the driven inputs at one edge and settle 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy_vec !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_busy_vec: got %h expected %h", busy_vec, 16'h0000);
      end
      checks++;
      if (rd_data !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0);
      end
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_rd_busy: got %b expected %b", rd_busy, 2'b00);
      end
   endtask

   task automatic test_init_read();
      set_read(0, 4'd7);
      set_read(1, 4'd8);
      tick();
      checks++;
      if (rd_data !== {32'hEEEE_3721, 32'hFFFF_856D}) begin
         errors++;
         $display("[TB] FAIL init_r7_r8: got %h expected %h", rd_data, {32'hEEEE_3721, 32'hFFFF_856D});
      end
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL init_busy: got %b expected %b", rd_busy, 2'b00);
      end
      set_read(0, 4'd11);
      set_read(1, 4'd3);
      tick();
      checks++;
      if (rd_data !== {32'h0000_0000, 32'hFFFF_765E}) begin
         errors++;
         $display("[TB] FAIL init_r11_r3: got %h expected %h", rd_data, {32'h0000_0000, 32'hFFFF_765E});
      end
      set_read(0, 4'd2);
      set_read(1, 4'd10);
      tick();
      checks++;
      if (rd_data !== {32'h1FFF_756F, 32'h0000_0060}) begin
         errors++;
         $display("[TB] FAIL init_r2_r10: got %h expected %h", rd_data, {32'h1FFF_756F, 32'h0000_0060});
      end
   endtask

   task automatic test_write_collision();
      logic [DATA_W-1:0] exp_same;
`ifdef RF_BYPASS_EN
      exp_same = 32'hDEAD_BEEF;
`else
      exp_same = 32'h0000_0000;
`endif
      set_write(0, 4'd3, 32'hDEAD_BEEF);
      set_read(0, 4'd3);
      tick();
      checks++;
      if (rd_data[31:0] !== exp_same) begin
         errors++;
         $display("[TB] FAIL collide_r3: got %h expected %h", rd_data[31:0], exp_same);
      end
      set_read(0, 4'd3);
      tick();
      checks++;
      if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL after_write_r3: got %h expected %h", rd_data[31:0], 32'hDEAD_BEEF);
      end
      set_read(1, 4'd1);
      tick();
      checks++;
      if (rd_data !== {32'h0000_0040, 32'hDEAD_BEEF}) begin
         errors++;
         $display("[TB] FAIL hold_port0: got %h expected %h", rd_data, {32'h0000_0040, 32'hDEAD_BEEF});
      end
   endtask

   task automatic test_dual_write();
      logic [DATA_W-1:0] exp_same;
`ifdef RF_BYPASS_EN
      exp_same = 32'h0000_0022;
`else
      exp_same = 32'h0000_0040;
`endif
      set_write(0, 4'd5, 32'h0000_0011);
      set_write(1, 4'd5, 32'h0000_0022);
      set_read(1, 4'd5);
      tick();
      checks++;
      if (rd_data[63:32] !== exp_same) begin
         errors++;
         $display("[TB] FAIL dual_collide_r5: got %h expected %h", rd_data[63:32], exp_same);
      end
      set_read(0, 4'd5);
      tick();
      checks++;
      if (rd_data[31:0] !== 32'h0000_0022) begin
         errors++;
         $display("[TB] FAIL dual_write_r5: got %h expected %h", rd_data[31:0], 32'h0000_0022);
      end
   endtask

   task automatic test_scoreboard();
      logic exp_busy;
      logic [DATA_W-1:0] exp_data;
`ifdef RF_BYPASS_EN
      exp_busy = 1'b0;
      exp_data = 32'h0000_0005;
`else
      exp_busy = 1'b1;
      exp_data = 32'h0000_0000;
`endif
      set_rsv(4'd9);
      tick();
      checks++;
      if (busy_vec !== 16'h0200) begin
         errors++;
         $display("[TB] FAIL rsv_r9: got %h expected %h", busy_vec, 16'h0200);
      end
      set_read(1, 4'd9);
      tick();
      checks++;
      if (busy_vec[9] !== 1'b1 || rd_busy[1] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rsv_r9_hold: got vec=%b rd=%b expected vec=1 rd=1", busy_vec[9], rd_busy[1]);
      end
      set_write(0, 4'd9, 32'h0000_0005);
      set_read(0, 4'd9);
      tick();
      checks++;
      if (busy_vec[9] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_clears_r9: got %b expected %b", busy_vec[9], 1'b0);
      end
      checks++;
      if (rd_busy[0] !== exp_busy || rd_data[31:0] !== exp_data) begin
         errors++;
         $display("[TB] FAIL collide_busy_r9: got busy=%b data=%h expected busy=%b data=%h", rd_busy[0], rd_data[31:0], exp_busy, exp_data);
      end
      set_rsv(4'd9);
      set_write(1, 4'd9, 32'h0000_0007);
      tick();
      checks++;
      if (busy_vec[9] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rsv_beats_write: got %b expected %b", busy_vec[9], 1'b1);
      end
      set_read(0, 4'd9);
      tick();
      checks++;
      if (rd_data[31:0] !== 32'h0000_0007 || rd_busy[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL read_r9_busy: got data=%h busy=%b expected data=%h busy=1", rd_data[31:0], rd_busy[0], 32'h0000_0007);
      end
      set_rsv(4'd9);
      tick();
      set_write(0, 4'd9, 32'h0000_0008);
      tick();
      checks++;
      if (busy_vec !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL no_count_r9: got %h expected %h", busy_vec, 16'h0000);
      end
   endtask

   task automatic test_zero_reg();
      set_write(1, 4'd0, 32'hFFFF_FFFF);
      set_rsv(4'd0);
      set_read(0, 4'd0);
      tick();
      checks++;
      if (busy_vec[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL r0_busy: got %b expected %b", busy_vec[0], 1'b0);
      end
      checks++;
      if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL r0_collide: got data=%h busy=%b expected data=0 busy=0", rd_data[31:0], rd_busy[0]);
      end
      set_read(1, 4'd0);
      tick();
      checks++;
      if (rd_data[63:32] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r0_read: got %h expected %h", rd_data[63:32], 32'h0);
      end
   endtask

   task automatic test_reset_mid_traffic();
      set_rsv(4'd13);
      tick();
      checks++;
      if (busy_vec !== 16'h2000) begin
         errors++;
         $display("[TB] FAIL pre_reset_busy: got %h expected %h", busy_vec, 16'h2000);
      end
      reset = 1'b1;
      set_write(0, 4'd7, 32'h0000_1234);
      set_rsv(4'd12);
      set_read(0, 4'd7);
      set_read(1, 4'd5);
      tick();
      reset = 1'b0;
      checks++;
      if (busy_vec !== 16'h0000 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL mid_reset: got vec=%h data=%h busy=%b expected vec=0 data=0 busy=0", busy_vec, rd_data, rd_busy);
      end
      set_read(0, 4'd7);
      set_read(1, 4'd5);
      tick();
      checks++;
      if (rd_data !== {32'h0000_0040, 32'hFFFF_856D}) begin
         errors++;
         $display("[TB] FAIL reinit_r7_r5: got %h expected %h", rd_data, {32'h0000_0040, 32'hFFFF_856D});
      end
      set_read(0, 4'd3);
      set_read(1, 4'd9);
      tick();
      checks++;
      if (rd_data !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reinit_r3_r9: got %h expected %h", rd_data, 64'h0);
      end
   endtask

   // Scenario sequence.
   initial begin
      reset    = 1'b0;
      rd_addr  = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_addr = '0;
      idle();
      @(negedge clk);
      test_reset();
      test_init_read();
      test_write_collision();
      test_dual_write();
      test_scoreboard();
      test_zero_reg();
      test_reset_mid_traffic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised multi-port register file, the successor to the CPU's single-write/dual-read register file. Provides NUM_RD registered read ports and NUM_WR write ports, with a per-register busy scoreboard for in-flight producers. Sits in the decode/operand-fetch stage; reads feed execute, writes come from writeback. Register 0 is hardwired to zero when ZERO_REG=1.

Parameters:
DATA_W, 32, register data width in bits
DEPTH, 16, number of registers (power of 2, >=4)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1: register 0 reads 0 and ignores writes and reservations

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD x ADDR_W  read addresses; ADDR_W=$clog2(DEPTH)
rd_data  out  NUM_RD x DATA_W  registered read data
rd_busy  out  NUM_RD  registered busy bit of the addressed register
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR x ADDR_W  write addresses
wr_data  in  NUM_WR x DATA_W  write data
rsv_en  in  1  reserve a register (mark busy)
rsv_addr  in  ADDR_W  register to reserve
busy_vec  out  DEPTH  current busy bits, direct from flops

Behaviour:
- Reset (reset=1 at posedge): every register loads RF_INIT[i] from the package (0 where not listed); all busy bits clear; rd_data=0; rd_busy=0. Reset overrides all same-cycle writes, reads and reservations.
- Read: 1-cycle latency. rd_en[p]=1 at edge N -> rd_data[p] and rd_busy[p] reflect the addressed register at edge N+1. rd_en[p]=0 -> rd_data[p] and rd_busy[p] hold.
- Write: wr_en[w]=1 updates the register at the posedge.
- Two write ports, same address, same cycle: higher port index wins.
- Write to register 0 with ZERO_REG=1 is dropped. Register 0 always reads 0 and is never busy.
- Scoreboard: rsv_en sets busy[rsv_addr]. Any wr_en to address a clears busy[a]. If a reservation and a write hit the same address in one cycle, the reservation wins and busy stays 1 (a newer producer was issued). Reserving an already-busy register keeps it busy; no counting.
- Read and write to the same address in one cycle: behaviour depends on RF_BYPASS_EN (below).
- Address widths are exact, so there is no out-of-range address. Data is stored and returned unmodified, with no sign handling.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: a read colliding with a same-cycle write captures wr_data, using the highest-index matching write port, and captures rd_busy as the post-update busy value.
- Undefined: the read captures the pre-write register contents and pre-update busy.
- Both builds have identical ports.

Decomposition:
Package cpu_pkg owns:
- reg_t, sint32_t
- RF_DEPTH_DEFAULT
- RF_INIT constant table: reg1=0x40, reg2=0x60, reg4=0x02, reg5=0x40, reg7=0xFFFF856D, reg8=0xEEEE3721, reg10=0x1FFF756F, reg11=0xFFFF765E
- RF_MAX_RD/RF_MAX_WR limits

Sub-module rf_scoreboard holds the busy vector and its set/clear/priority logic. It is instantiated once.

Test Plan:
1. Reset then read r7 and r8 on ports 0/1 -> next cycle rd_data = 0xFFFF856D / 0xEEEE3721, rd_busy=0.
2. wr_en[0], addr=3, data=0xDEADBEEF, with a same-cycle read of r3 -> bypass build returns 0xDEADBEEF. Non-bypass build returns 0x0, then 0xDEADBEEF on the following read.
3. NUM_WR=2, both ports write r5 (0x11 on port 0, 0x22 on port 1) -> r5 reads 0x22.
4. rsv r9, then write r9 = 0x5 -> busy_vec[9] is 1 for exactly the cycles between the two edges, then 0. Reserve and write r9 in the same cycle -> busy_vec[9] stays 1.
5. Write 0xFFFFFFFF to r0 and rsv r0 -> r0 reads 0 and busy_vec[0]=0.
6. reset asserted mid-traffic while a write and reservation are pending -> all registers return to RF_INIT, busy_vec=0, rd_data=0 the next cycle.
